// File: rtl/otter_cu_fsm_if.sv
// Control-unit <-> datapath signal bundle for the OTTER multicycle sequencer.
// The master side is the sequencer; the slave side is the datapath and memories.
interface otter_cu_fsm_if #(
    parameter int RETIRE_W = 32
);
    logic                CU_INTR;
    logic                CU_MIE;
    logic [6:0]          CU_OPCODE;
    logic [2:0]          CU_FUNC3;
    logic                CU_IMEM_RDY;
    logic                CU_DMEM_RDY;
    logic                CU_RST;
    logic                CU_MEMRDEN1;
    logic                CU_IR_LD;
    logic                CU_MEMRDEN2;
    logic                CU_MEMWE2;
    logic                CU_REGWRITE;
    logic                CU_PCWRITE;
    logic                CU_CSR_WE;
    logic                CU_MRET;
    logic                CU_INT_TAKEN;
    logic                CU_ILLEGAL;
    logic [RETIRE_W-1:0] CU_RETIRED;

    modport master (
        input  CU_INTR, CU_MIE, CU_OPCODE, CU_FUNC3, CU_IMEM_RDY, CU_DMEM_RDY,
        output CU_RST, CU_MEMRDEN1, CU_IR_LD, CU_MEMRDEN2, CU_MEMWE2, CU_REGWRITE,
               CU_PCWRITE, CU_CSR_WE, CU_MRET, CU_INT_TAKEN, CU_ILLEGAL, CU_RETIRED
    );

    modport slave (
        output CU_INTR, CU_MIE, CU_OPCODE, CU_FUNC3, CU_IMEM_RDY, CU_DMEM_RDY,
        input  CU_RST, CU_MEMRDEN1, CU_IR_LD, CU_MEMRDEN2, CU_MEMWE2, CU_REGWRITE,
               CU_PCWRITE, CU_CSR_WE, CU_MRET, CU_INT_TAKEN, CU_ILLEGAL, CU_RETIRED
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// Multicycle control sequencer for the OTTER RV32I core: FETCH -> EXEC [-> MEM [-> WB]],
// with traps and interrupts taken only at instruction boundaries.
module otter_cu_fsm #(
    parameter int RETIRE_W = 32,
    parameter int INT_SYNC = 1
) (
    input logic             CLK,
    input logic             RST,
    otter_cu_fsm_if.master  bus
);
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        ST_INIT, ST_FETCH, ST_EXEC, ST_MEM, ST_WB, ST_INTR
    } state_e;

    state_e              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                intr_s;
    logic                retire;

    logic cu_rst, memrden1, ir_ld, memrden2, memwe2, regwrite;
    logic pcwrite, csr_we, mret, int_taken, illegal;

    generate
        if (INT_SYNC != 0) begin : g_sync
            logic [1:0] sync_q;
            always_ff @(posedge CLK) begin
                if (RST) sync_q <= '0;
                else     sync_q <= {sync_q[0], bus.CU_INTR};
            end
            assign intr_s = sync_q[1];
        end else begin : g_nosync
            assign intr_s = bus.CU_INTR;
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        retire     = 1'b0;
        cu_rst     = 1'b0;
        memrden1   = 1'b0;
        ir_ld      = 1'b0;
        memrden2   = 1'b0;
        memwe2     = 1'b0;
        regwrite   = 1'b0;
        pcwrite    = 1'b0;
        csr_we     = 1'b0;
        mret       = 1'b0;
        int_taken  = 1'b0;
        illegal    = 1'b0;

        unique case (state_q)
            ST_INIT: begin
                cu_rst  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                memrden1 = 1'b1;
                if (bus.CU_IMEM_RDY) begin
                    ir_ld   = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                case (bus.CU_OPCODE)
                    OPC_LOAD: begin
                        memrden2   = 1'b1;
                        is_store_d = 1'b0;
                        state_d    = ST_MEM;
                    end
                    OPC_STORE: begin
                        memwe2     = 1'b1;
                        is_store_d = 1'b1;
                        state_d    = ST_MEM;
                    end
                    OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: begin
                        regwrite = 1'b1;
                        pcwrite  = 1'b1;
                        retire   = 1'b1;
                    end
                    OPC_BRANCH: begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                    end
                    OPC_SYSTEM: begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                        if (bus.CU_FUNC3 != 3'b000) begin
                            csr_we   = 1'b1;
                            regwrite = 1'b1;
                        end else begin
                            mret = 1'b1;
                        end
                    end
                    default: begin
                        // Unknown opcode traps unconditionally; MIE does not gate it.
                        illegal = 1'b1;
                        state_d = ST_INTR;
                    end
                endcase
            end
            ST_MEM: begin
                memwe2   = is_store_q;
                memrden2 = ~is_store_q;
                if (bus.CU_DMEM_RDY) begin
                    if (is_store_q) begin
                        pcwrite = 1'b1;
                        retire  = 1'b1;
                    end else begin
                        state_d = ST_WB;
                    end
                end
            end
            ST_WB: begin
                regwrite = 1'b1;
                pcwrite  = 1'b1;
                retire   = 1'b1;
            end
            ST_INTR: begin
                int_taken = 1'b1;
                pcwrite   = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_INIT;
        endcase

        // Interrupts are sampled only at a retire boundary, using the pre-MRET MIE.
        if (retire) state_d = (intr_s & bus.CU_MIE) ? ST_INTR : ST_FETCH;

        if (RST) begin
            state_d   = ST_INIT;
            retire    = 1'b0;
            cu_rst    = 1'b0;
            memrden1  = 1'b0;
            ir_ld     = 1'b0;
            memrden2  = 1'b0;
            memwe2    = 1'b0;
            regwrite  = 1'b0;
            pcwrite   = 1'b0;
            csr_we    = 1'b0;
            mret      = 1'b0;
            int_taken = 1'b0;
            illegal   = 1'b0;
        end

        retired_d = retire ? retired_q + 1'b1 : retired_q;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_INIT;
            is_store_q <= 1'b0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            retired_q  <= retired_d;
        end
    end

    assign bus.CU_RST       = cu_rst;
    assign bus.CU_MEMRDEN1  = memrden1;
    assign bus.CU_IR_LD     = ir_ld;
    assign bus.CU_MEMRDEN2  = memrden2;
    assign bus.CU_MEMWE2    = memwe2;
    assign bus.CU_REGWRITE  = regwrite;
    assign bus.CU_PCWRITE   = pcwrite;
    assign bus.CU_CSR_WE    = csr_we;
    assign bus.CU_MRET      = mret;
    assign bus.CU_INT_TAKEN = int_taken;
    assign bus.CU_ILLEGAL   = illegal;
    assign bus.CU_RETIRED   = retired_q;
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed stimulus for the OTTER control sequencer; expected strobes per cycle are queued
// by the driver and checked by an independent negedge monitor.
module tb_otter_cu_fsm;
    localparam int RW = 4;

    // {RST, RDEN1, IR_LD, RDEN2, WE2, REGW, PCW, CSR_WE, MRET, INT_TAKEN, ILLEGAL}
    localparam logic [10:0] S_NONE  = 11'h000;
    localparam logic [10:0] S_INIT  = 11'h400;
    localparam logic [10:0] S_FETCH = 11'h200;
    localparam logic [10:0] S_FRDY  = 11'h300;
    localparam logic [10:0] S_RD2   = 11'h080;
    localparam logic [10:0] S_WE2   = 11'h040;
    localparam logic [10:0] S_STRET = 11'h050;
    localparam logic [10:0] S_REGPC = 11'h030;
    localparam logic [10:0] S_PC    = 11'h010;
    localparam logic [10:0] S_CSR   = 11'h038;
    localparam logic [10:0] S_MRET  = 11'h014;
    localparam logic [10:0] S_INTR  = 11'h012;
    localparam logic [10:0] S_ILL   = 11'h001;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ADDI  = 7'b0010011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_SYS   = 7'b1110011;
    localparam logic [6:0] OP_BAD   = 7'b1111111;

    typedef struct {
        logic [10:0]   s;
        logic [RW-1:0] r;
        string         tag;
    } exp_t;

    logic CLK = 1'b0;
    logic RST;
    otter_cu_fsm_if #(.RETIRE_W(RW)) bus ();

    otter_cu_fsm #(.RETIRE_W(RW), .INT_SYNC(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    exp_t          q[$];
    logic [RW-1:0] exp_ret;
    int            n_cmp  = 0;
    int            n_fail = 0;
    bit            done   = 1'b0;

    function automatic logic [10:0] strobes();
        return {bus.CU_RST, bus.CU_MEMRDEN1, bus.CU_IR_LD, bus.CU_MEMRDEN2, bus.CU_MEMWE2,
                bus.CU_REGWRITE, bus.CU_PCWRITE, bus.CU_CSR_WE, bus.CU_MRET,
                bus.CU_INT_TAKEN, bus.CU_ILLEGAL};
    endfunction

    // One clock of stimulus plus the strobes/counter that cycle must show.
    task automatic cyc(input logic [6:0] op, input logic [2:0] f3, input logic im,
                       input logic dm, input logic [10:0] s, input bit ret, input string tag);
        exp_t e;
        bus.CU_OPCODE   = op;
        bus.CU_FUNC3    = f3;
        bus.CU_IMEM_RDY = im;
        bus.CU_DMEM_RDY = dm;
        e.s = s; e.r = exp_ret; e.tag = tag;
        q.push_back(e);
        if (ret) exp_ret = exp_ret + 1'b1;
        @(posedge CLK); #1;
    endtask

    task automatic fetch(input logic [6:0] op, input logic [2:0] f3, input int w, input string tag);
        repeat (w) cyc(op, f3, 1'b0, 1'b0, S_FETCH, 1'b0, tag);
        cyc(op, f3, 1'b1, 1'b0, S_FRDY, 1'b0, tag);
    endtask

    task automatic alu(input logic [6:0] op, input logic [2:0] f3, input logic [10:0] sx,
                       input int w, input string tag);
        fetch(op, f3, w, tag);
        cyc(op, f3, 1'b1, 1'b0, sx, 1'b1, tag);
    endtask

    task automatic load(input int w);
        fetch(OP_LOAD, 3'b010, 0, "lw");
        cyc(OP_LOAD, 3'b010, 1'b0, 1'b1, S_RD2, 1'b0, "lw_exec");
        repeat (w) cyc(OP_LOAD, 3'b010, 1'b1, 1'b0, S_RD2, 1'b0, "lw_wait");
        cyc(OP_LOAD, 3'b010, 1'b1, 1'b1, S_RD2, 1'b0, "lw_rdy");
        cyc(OP_LOAD, 3'b010, 1'b1, 1'b0, S_REGPC, 1'b1, "lw_wb");
    endtask

    task automatic store(input int w);
        fetch(OP_STORE, 3'b010, 0, "sw");
        cyc(OP_STORE, 3'b010, 1'b0, 1'b1, S_WE2, 1'b0, "sw_exec");
        repeat (w) cyc(OP_STORE, 3'b010, 1'b1, 1'b0, S_WE2, 1'b0, "sw_wait");
        cyc(OP_STORE, 3'b010, 1'b1, 1'b1, S_STRET, 1'b1, "sw_rdy");
    endtask

    initial begin
        RST = 1'b1;
        bus.CU_INTR = 1'b0; bus.CU_MIE = 1'b0; bus.CU_OPCODE = '0; bus.CU_FUNC3 = '0;
        bus.CU_IMEM_RDY = 1'b0; bus.CU_DMEM_RDY = 1'b0;
        exp_ret = '0;
        @(posedge CLK); #1;
        cyc(OP_ADDI, 3'b000, 1'b1, 1'b1, S_NONE, 1'b0, "rst_hold");
        cyc(OP_ADDI, 3'b000, 1'b1, 1'b1, S_NONE, 1'b0, "rst_hold");
        RST = 1'b0;
        cyc(OP_ADDI, 3'b000, 1'b0, 1'b0, S_INIT, 1'b0, "init");

        for (int i = 0; i < 10; i++) alu(OP_ADDI, 3'b000, S_REGPC, 0, "addi");
        alu(OP_LUI, 3'b000, S_REGPC, 2, "lui_imem_wait");
        alu(OP_BR,  3'b001, S_PC,    0, "branch");
        alu(OP_SYS, 3'b001, S_CSR,   0, "csrrw");
        // MRET sees the pre-restore MIE=0, so a pending line does not trap here.
        bus.CU_INTR = 1'b1;
        alu(OP_SYS, 3'b000, S_MRET,  0, "mret");
        bus.CU_INTR = 1'b0;
        repeat (2) alu(OP_JAL, 3'b000, S_REGPC, 0, "jal_drain_sync");

        load(3);
        store(0);

        // Interrupt pending during a stalled store must wait for the retire.
        bus.CU_INTR = 1'b1; bus.CU_MIE = 1'b1;
        store(2);
        cyc(OP_ADDI, 3'b000, 1'b0, 1'b0, S_INTR, 1'b0, "trap");
        bus.CU_MIE = 1'b0;
        alu(OP_ADDI, 3'b000, S_REGPC, 0, "no_trap_mie0");
        bus.CU_INTR = 1'b0;
        repeat (2) alu(OP_ADDI, 3'b000, S_REGPC, 0, "addi_drain_sync");

        bus.CU_MIE = 1'b1;
        fetch(OP_BAD, 3'b000, 0, "bad");
        cyc(OP_BAD, 3'b000, 1'b1, 1'b0, S_ILL, 1'b0, "illegal");
        cyc(OP_BAD, 3'b000, 1'b1, 1'b0, S_INTR, 1'b0, "illegal_trap");
        bus.CU_MIE = 1'b0;
        fetch(OP_BAD, 3'b000, 0, "bad_mie0");
        cyc(OP_BAD, 3'b000, 1'b1, 1'b0, S_ILL, 1'b0, "illegal_mie0");
        cyc(OP_BAD, 3'b000, 1'b1, 1'b0, S_INTR, 1'b0, "illegal_trap_mie0");

        // Reset during a store's MEM wait: the write must not complete.
        fetch(OP_STORE, 3'b010, 0, "sw_rst");
        cyc(OP_STORE, 3'b010, 1'b1, 1'b0, S_WE2, 1'b0, "sw_rst_exec");
        cyc(OP_STORE, 3'b010, 1'b1, 1'b0, S_WE2, 1'b0, "sw_rst_wait");
        RST = 1'b1;
        cyc(OP_STORE, 3'b010, 1'b1, 1'b1, S_NONE, 1'b0, "sw_rst_abort");
        exp_ret = '0;
        RST = 1'b0;
        cyc(OP_STORE, 3'b010, 1'b1, 1'b1, S_INIT, 1'b0, "reinit");

        for (int i = 0; i < 17; i++) alu(OP_ADDI, 3'b000, S_REGPC, 0, "wrap");
        cyc(OP_ADDI, 3'b000, 1'b0, 1'b0, S_FETCH, 1'b0, "wrap_end");
        done = 1'b1;
    end

    initial begin
        exp_t e;
        logic [10:0] got;
        forever begin
            @(negedge CLK);
            got = strobes();
            n_cmp++;
            if ($countones(got[9] + 2'(got[7]) + 2'(got[6])) > 1 ||
                (int'(got[9]) + int'(got[7]) + int'(got[6])) > 1) begin
                n_fail++;
                $display("FAIL mutex: got strobes=%h, required at most one of RDEN1/RDEN2/WE2", got);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                n_cmp++;
                if (got !== e.s || bus.CU_RETIRED !== e.r) begin
                    n_fail++;
                    $display("FAIL %s: got strobes=%h retired=%0d, required strobes=%h retired=%0d",
                             e.tag, got, bus.CU_RETIRED, e.s, e.r);
                end
            end
        end
    end

    initial begin
        int budget;
        budget = 0;
        while (!done && budget < 5000) begin
            @(posedge CLK);
            budget++;
        end
        repeat (2) @(posedge CLK);
        n_cmp++;
        if (!done || q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got done=%0d pending=%0d, required done=1 pending=0", done, q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
